// File: rtl/td4_progmem_if.sv
// Core fetch port and byte-wide program-load stream of the TD4 program memory.
// master drives ip and the load stream; slave is the memory/loader.
interface td4_progmem_if;
    logic [3:0] ip;
    logic [7:0] op;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       busy;
    logic       err;
    logic       core_rst_n;

    modport master (
        output ip, ld_start, ld_valid, ld_data,
        input  op, ld_ready, busy, err, core_rst_n
    );

    modport slave (
        input  ip, ld_start, ld_valid, ld_data,
        output op, ld_ready, busy, err, core_rst_n
    );
endinterface

// File: rtl/td4_progmem.sv
// TD4 16x8 program memory with a stream loader that holds the core in reset while loading.
// Define TD4_PROGMEM_CHKSUM_EN to require a 17th checksum byte and enable the ERR state.
module td4_progmem (
    input  logic          clk,
    input  logic          rst_n,
    td4_progmem_if.slave  bus
);

`ifdef TD4_PROGMEM_CHKSUM_EN
    typedef enum logic [1:0] {RUN, LOAD, ERR} state_t;
`else
    typedef enum logic {RUN, LOAD} state_t;
`endif

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg;
    logic [7:0] mem_reg [16];
    logic       ld_ready_reg;
    logic       busy_reg;
    logic       core_rst_reg;
    logic       accept;
    logic       wr_en;

`ifdef TD4_PROGMEM_CHKSUM_EN
    logic [7:0] sum_reg;
    logic [7:0] sum_next;
    logic       err_reg;

    assign sum_next = sum_reg + bus.ld_data;
`endif

    // ld_ready_reg is high exactly while the FSM sits in LOAD
    assign accept = ld_ready_reg & bus.ld_valid;
    assign wr_en  = accept & (cnt_reg < 5'd16);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (bus.ld_start) state_next = LOAD;
            end
            LOAD: begin
`ifdef TD4_PROGMEM_CHKSUM_EN
                if (accept && cnt_reg == 5'd16)
                    state_next = (sum_next == 8'h00) ? RUN : ERR;
`else
                if (accept && cnt_reg == 5'd15)
                    state_next = RUN;
`endif
            end
`ifdef TD4_PROGMEM_CHKSUM_EN
            ERR: begin
                if (bus.ld_start) state_next = LOAD;
            end
`endif
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            ld_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            core_rst_reg <= 1'b0;
`ifdef TD4_PROGMEM_CHKSUM_EN
            sum_reg      <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            ld_ready_reg <= (state_next == LOAD);
            busy_reg     <= (state_next == LOAD);
            // Core runs only once the FSM is back in RUN
            core_rst_reg <= (state_next == RUN);
`ifdef TD4_PROGMEM_CHKSUM_EN
            err_reg      <= (state_next == ERR);
`endif
            if (state_reg != LOAD) begin
                cnt_reg <= '0;
`ifdef TD4_PROGMEM_CHKSUM_EN
                sum_reg <= '0;
`endif
            end else if (accept) begin
                if (wr_en) cnt_reg <= cnt_reg + 5'd1;
`ifdef TD4_PROGMEM_CHKSUM_EN
                sum_reg <= sum_next;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem_reg[i] <= 8'h00;
        end else if (wr_en) begin
            mem_reg[cnt_reg[3:0]] <= bus.ld_data;
        end
    end

    assign bus.op         = mem_reg[bus.ip];
    assign bus.ld_ready   = ld_ready_reg;
    assign bus.busy       = busy_reg;
    assign bus.core_rst_n = core_rst_reg;
`ifdef TD4_PROGMEM_CHKSUM_EN
    assign bus.err        = err_reg;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_td4_progmem.sv
// Directed + randomized bench for td4_progmem against an array model of the program memory.
`timescale 1ns/1ps
module tb_td4_progmem;

`ifdef TD4_PROGMEM_CHKSUM_EN
    localparam int LOAD_LEN = 17;
    localparam bit CHK      = 1'b1;
`else
    localparam int LOAD_LEN = 16;
    localparam bit CHK      = 1'b0;
`endif

    logic clk;
    logic rst_n;
    td4_progmem_if bus();

    td4_progmem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_mem [16];
    logic [7:0] stim [17];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A load succeeds when all bytes (checksum included) sum to zero mod 256
    function automatic bit expect_good();
        logic [7:0] s;
        if (!CHK) return 1'b1;
        s = 8'h00;
        for (int i = 0; i < 17; i++) s = s + stim[i];
        return (s == 8'h00);
    endfunction

    task automatic fill_stim(input bit random_data, input bit good_chk);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            stim[i] = random_data ? 8'($urandom) : 8'(i);
            s = s + stim[i];
        end
        stim[16] = 8'h00 - s;
        if (!good_chk) stim[16] = stim[16] - 8'd1;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.ip = 4'(i);
            #1;
            check(tag, bus.op, model_mem[i]);
        end
        step();
    endtask

    task automatic do_load(input int stall_pct, input int start_at, input int abort_at);
        int busy_cycles;
        int stalls;
        bit good;
        busy_cycles = 0;
        stalls = 0;
        good = expect_good();
        // ld_valid alongside ld_start in RUN must not be accepted
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = ~model_mem[0];
        bus.ip       = 4'd0;
        step();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        if (bus.busy) busy_cycles++;
        check("start_ready", bus.ld_ready, 1);
        check("start_core_held", bus.core_rst_n, 0);
        check("start_no_write", bus.op, model_mem[0]);
        for (int k = 0; k < LOAD_LEN; k++) begin
            if (k == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
                check("abort_busy", bus.busy, 0);
                check("abort_ready", bus.ld_ready, 0);
                check("abort_err", bus.err, 0);
                check("abort_core_rst", bus.core_rst_n, 0);
                for (int i = 0; i < 8; i++) begin
                    bus.ip = 4'(i);
                    #0.1;
                    check("abort_op", bus.op, 8'h00);
                end
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("abort_core_before_edge", bus.core_rst_n, 0);
                step();
                check("abort_core_after_edge", bus.core_rst_n, 1);
                check("abort_busy_after", bus.busy, 0);
                $display("load aborted by reset after %0d bytes", k);
                return;
            end
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(99) >= stall_pct) break;
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'($urandom);
                if (k < 16) bus.ip = 4'(k);
                step();
                stalls++;
                if (bus.busy) busy_cycles++;
                check("stall_busy", bus.busy, 1);
                if (k < 16) check("stall_no_write", bus.op, model_mem[k]);
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = stim[k];
            bus.ld_start = (k == start_at);
            step();
            bus.ld_valid = 1'b0;
            bus.ld_start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (k < 16) begin
                model_mem[k] = stim[k];
                bus.ip = 4'(k);
                #1;
                check("write_visible", bus.op, stim[k]);
            end
            if (k < LOAD_LEN - 1) begin
                check("load_ready", bus.ld_ready, 1);
                check("load_core_held", bus.core_rst_n, 0);
            end
        end
        check("end_busy", bus.busy, 0);
        check("end_ready", bus.ld_ready, 0);
        check("end_err", bus.err, !good);
        check("end_core_rst", bus.core_rst_n, good);
        check("busy_cycles", busy_cycles, LOAD_LEN + stalls);
        step();
        check("after_core_rst", bus.core_rst_n, good);
        check("after_err", bus.err, !good);
        $display("load done: %0d bytes, %0d stalls, good=%0d err=%0b core_rst_n=%0b",
                 LOAD_LEN, stalls, good, bus.err, bus.core_rst_n);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        rst_n        = 1'b0;
        bus.ip       = 4'd0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.ld_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_core_rst", bus.core_rst_n, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_core_before_edge", bus.core_rst_n, 0);
        step();
        check("rst_core_after_edge", bus.core_rst_n, 1);
        check_mem("rst_mem");

        fill_stim(1'b0, 1'b1);
        do_load(0, -1, -1);
        check_mem("good_mem");

        if (CHK) begin
            fill_stim(1'b0, 1'b0);
            do_load(0, -1, -1);
            check_mem("bad_mem");
            fill_stim(1'b1, 1'b1);
            do_load(0, -1, -1);
            check_mem("recover_mem");
        end

        fill_stim(1'b0, 1'b1);
        do_load(40, -1, -1);
        check_mem("stall_seq_mem");

        fill_stim(1'b1, 1'b1);
        do_load(30, -1, -1);
        check_mem("stall_rand_mem");

        fill_stim(1'b1, 1'b1);
        do_load(0, 5, -1);
        check_mem("ignored_start_mem");

        fill_stim(1'b1, 1'b1);
        do_load(0, -1, 8);
        check_mem("abort_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
